// File: rtl/energy_link_pkg.sv
// Shared constants and types for the energy telemetry serial link.
package energy_link_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         CSUM_W    = 8;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VOLT,
    ST_CURR,
    ST_CSUM
  } frame_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [CSUM_W-1:0] frame_csum(input logic [7:0] v, input logic [7:0] c);
    logic [CSUM_W-1:0] s;
    s = v + c;
    return s;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: two-flop synchronizer, midpoint sampling, stop-bit check.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_stb,
  output logic       rx_frm_err
);
  import energy_link_pkg::*;

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          stb_q, stb_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    stb_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          // line back high at mid start bit: glitch, drop silently
          if (!sync2_q) begin
            state_d = RX_DATA;
            cnt_d   = FULL_M1;
            bit_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          state_d = RX_IDLE;
          if (sync2_q) stb_d = 1'b1;
          else         ferr_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      stb_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stb_q   <= stb_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte    = shift_q;
  assign rx_stb     = stb_q;
  assign rx_frm_err = ferr_q;

endmodule

// File: rtl/energy_telemetry_rx.sv
// Telemetry frame decoder: SYNC, VOLT, CURR, CSUM frames into a held output register.
//  state | meaning
//  HUNT  | waiting for sync byte 0xA5, other bytes ignored
//  VOLT  | next byte is the voltage sample
//  CURR  | next byte is the current sample
//  CSUM  | next byte is the checksum, frame completes on it
module energy_telemetry_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [7:0]  voltage,
  output logic [7:0]  current,
  output logic [15:0] power,
  output logic        csum_err,
  output logic        frm_err,
  output logic        overrun,
  output logic [7:0]  err_count
);
  import energy_link_pkg::*;

  localparam int            TW     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT_CLKS - 1);

  logic [7:0] rx_byte;
  logic       rx_stb, rx_frm_err;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_byte    (rx_byte),
    .rx_stb     (rx_stb),
    .rx_frm_err (rx_frm_err)
  );

  frame_state_e st_q, st_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    vb_q, vb_d, cb_q, cb_d;
  logic          valid_q, valid_d;
  logic [7:0]    volt_q, volt_d, curr_q, curr_d;
  logic [15:0]   power_q, power_d;
  logic          csum_err_q, csum_err_d;
  logic          frm_err_q, frm_err_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [8:0]    esum;

  always_comb begin
    st_d       = st_q;
    tmo_d      = tmo_q;
    vb_d       = vb_q;
    cb_d       = cb_q;
    valid_d    = valid_q;
    volt_d     = volt_q;
    curr_d     = curr_q;
    power_d    = power_q;
    csum_err_d = 1'b0;
    frm_err_d  = 1'b0;
    overrun_d  = 1'b0;

    if (valid_q && frame_ready) valid_d = 1'b0;

    if (rx_frm_err) begin
      st_d      = ST_HUNT;
      frm_err_d = 1'b1;
    end else if (rx_stb) begin
      tmo_d = TMO_M1;
      case (st_q)
        ST_HUNT: if (rx_byte == SYNC_BYTE) st_d = ST_VOLT;
        ST_VOLT: begin
          vb_d = rx_byte;
          st_d = ST_CURR;
        end
        ST_CURR: begin
          cb_d = rx_byte;
          st_d = ST_CSUM;
        end
        ST_CSUM: begin
          st_d = ST_HUNT;
          if (rx_byte == frame_csum(vb_q, cb_q)) begin
            // an accept in this same cycle frees the register for the new frame
            if (valid_q && !frame_ready) begin
              overrun_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              volt_d  = vb_q;
              curr_d  = cb_q;
              power_d = {8'b0, vb_q} * {8'b0, cb_q};
            end
          end else begin
            csum_err_d = 1'b1;
          end
        end
        default: st_d = ST_HUNT;
      endcase
    end else if (st_q != ST_HUNT) begin
      if (tmo_q == '0) begin
        frm_err_d = 1'b1;
        st_d      = ST_HUNT;
      end else begin
        tmo_d = tmo_q - TW'(1);
      end
    end

    esum = {1'b0, err_cnt_q} + 9'(csum_err_d) + 9'(frm_err_d) + 9'(overrun_d);
    err_cnt_d = (esum > 9'd255) ? 8'hFF : esum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_HUNT;
      tmo_q      <= '0;
      vb_q       <= '0;
      cb_q       <= '0;
      valid_q    <= 1'b0;
      volt_q     <= '0;
      curr_q     <= '0;
      power_q    <= '0;
      csum_err_q <= 1'b0;
      frm_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      st_q       <= st_d;
      tmo_q      <= tmo_d;
      vb_q       <= vb_d;
      cb_q       <= cb_d;
      valid_q    <= valid_d;
      volt_q     <= volt_d;
      curr_q     <= curr_d;
      power_q    <= power_d;
      csum_err_q <= csum_err_d;
      frm_err_q  <= frm_err_d;
      overrun_q  <= overrun_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign frame_valid = valid_q;
  assign voltage     = volt_q;
  assign current     = curr_q;
  assign power       = power_q;
  assign csum_err    = csum_err_q;
  assign frm_err     = frm_err_q;
  assign overrun     = overrun_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_energy_telemetry_rx.sv
// Bench for energy_telemetry_rx: frame-level model checked every cycle plus literal pins.
module tb_energy_telemetry_rx;
  localparam int CPB  = 16;
  localparam int TMO  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        frame_ready = 1'b1;
  logic        frame_valid;
  logic [7:0]  voltage, current;
  logic [15:0] power;
  logic        csum_err, frm_err, overrun;
  logic [7:0]  err_count;

  energy_telemetry_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .voltage     (voltage),
    .current     (current),
    .power       (power),
    .csum_err    (csum_err),
    .frm_err     (frm_err),
    .overrun     (overrun),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: bytes collected in a queue, judged once four are in.
  logic [7:0] fq[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_v = 8'h00, m_c = 8'h00;
  int         m_err = 0;
  int         m_csum = 0, m_frm = 0, m_ovr = 0;

  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [7:0] s;
    if (!ok) begin
      m_frm++; m_err++;
      fq.delete();
    end else if (fq.size() == 0) begin
      if (b == 8'hA5) fq.push_back(b);
    end else begin
      fq.push_back(b);
      if (fq.size() == 4) begin
        s = fq[1] + fq[2];
        if (fq[3] == s) begin
          if (m_valid && !frame_ready) begin
            m_ovr++; m_err++;
          end else begin
            m_v = fq[1];
            m_c = fq[2];
            m_valid = !frame_ready;
          end
        end else begin
          m_csum++; m_err++;
        end
        fq.delete();
      end
    end
  endtask

  task automatic model_timeout();
    if (fq.size() != 0) begin
      m_frm++; m_err++;
      fq.delete();
    end
  endtask

  // Per-cycle monitor and compare.
  bit cmp_en = 1'b0;
  int cyc = 0;
  int n_csum = 0, n_frm = 0, n_ovr = 0, n_vcyc = 0;
  int last_frm_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (csum_err) n_csum++;
    if (frm_err) begin n_frm++; last_frm_cyc = cyc; end
    if (overrun) n_ovr++;
    if (frame_valid) n_vcyc++;
    if (cmp_en && !rst) begin
      chk("frame_valid", frame_valid, m_valid);
      chk("voltage", voltage, m_v);
      chk("current", current, m_c);
      chk("power", power, m_v * m_c);
      chk("err_count", err_count, (m_err > 255) ? 255 : m_err);
      chk("csum_err_pulses", n_csum, m_csum);
      chk("frm_err_pulses", n_frm, m_frm);
      chk("overrun_pulses", n_ovr, m_ovr);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    cmp_en = 1'b0;
    rxd = stop_ok;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    model_byte(b, stop_ok);
    repeat (4) @(negedge clk);
    cmp_en = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic [7:0] c, input logic [7:0] s);
    send_byte(8'hA5, 1'b1);
    send_byte(v, 1'b1);
    send_byte(c, 1'b1);
    send_byte(s, 1'b1);
  endtask

  task automatic do_reset();
    cmp_en = 1'b0;
    rxd = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fq.delete();
    m_valid = 1'b0; m_v = 8'h00; m_c = 8'h00; m_err = 0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
  endtask

  initial begin
    repeat (200000) @(negedge clk);
    $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, t_end;
    do_reset();
    chk("rst_valid", frame_valid, 0);
    chk("rst_power", power, 16'h0000);
    chk("rst_err_count", err_count, 0);

    // Good frame, consumer always ready
    frame_ready = 1'b1;
    v0 = n_vcyc;
    send_frame(8'h96, 8'h55, 8'hEB);
    chk("good_valid_cycles", n_vcyc - v0, 1);
    chk("good_voltage", voltage, 8'h96);
    chk("good_current", current, 8'h55);
    chk("good_power", power, 16'h31CE);

    // Bad checksum, then the corrected frame
    do_reset();
    v0 = n_vcyc;
    send_frame(8'h2D, 8'hFF, 8'h00);
    chk("csum_pulse", n_csum, 1);
    chk("csum_no_valid", n_vcyc - v0, 0);
    chk("csum_err_count", err_count, 1);
    send_frame(8'h2D, 8'hFF, 8'h2C);
    chk("csum_fix_power", power, 16'h2CD3);

    // Held output, second frame overruns
    do_reset();
    frame_ready = 1'b0;
    send_frame(8'h10, 8'h20, 8'h30);
    chk("hold_valid", frame_valid, 1);
    send_frame(8'h03, 8'h04, 8'h07);
    chk("ovr_pulse", n_ovr, 1);
    chk("ovr_held_voltage", voltage, 8'h10);
    chk("ovr_held_power", power, 16'h0200);
    chk("ovr_err_count", err_count, 1);
    cmp_en = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("accept_clears", frame_valid, 0);

    // Inter-byte timeout
    do_reset();
    f0 = n_frm;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h96, 1'b1);
    t_end = cyc;
    repeat (3900) @(negedge clk);
    cmp_en = 1'b0;
    repeat (300) @(negedge clk);
    model_timeout();
    cmp_en = 1'b1;
    chk("tmo_pulse", n_frm - f0, 1);
    chk("tmo_not_early", (last_frm_cyc >= t_end + 4070) ? 1 : 0, 1);
    chk("tmo_not_late", (last_frm_cyc <= t_end + 4110) ? 1 : 0, 1);
    send_frame(8'h01, 8'h02, 8'h03);
    chk("tmo_next_power", power, 16'h0002);

    // Bad stop bit inside a frame, then a short glitch between bytes
    f0 = n_frm;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h55, 1'b0);
    chk("stop_frm_pulse", n_frm - f0, 1);
    send_byte(8'hA5, 1'b1);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_no_frm", n_frm - f0, 1);
    send_byte(8'h7F, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'hFF, 1'b1);
    chk("glitch_voltage", voltage, 8'h7F);
    chk("glitch_power", power, 16'h3F80);

    // Reset in the middle of the CURR byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h2D, 1'b1);
    rxd = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    do_reset();
    chk("midrst_voltage", voltage, 0);
    chk("midrst_current", current, 0);
    chk("midrst_power", power, 0);
    chk("midrst_err_count", err_count, 0);
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h2D, 8'hFF, 8'h2C);
    chk("midrst_next_voltage", voltage, 8'h2D);
    chk("midrst_next_power", power, 16'h2CD3);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
